// File: rtl/sqrt_pkg.sv
// Shared types and elaboration helpers for the iterative square-root unit.
package sqrt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   // Root width for a given operand width.
   function automatic int root_w(input int width);
      return width / 2;
   endfunction

   // Step-counter width: clog2 of the number of BUSY cycles, never below 1 bit.
   function automatic int cnt_w(input int width, input int steps);
      int n;
      n = (width / 2) / steps;
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Legal parameter combination: even width of at least 4, STEPS dividing the root width.
   function automatic bit params_ok(input int width, input int steps);
      return (width >= 4) && (width % 2 == 0) && (steps >= 1) && ((width / 2) % steps == 0);
   endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring square-root iteration: consumes the next operand bit pair,
// resolves one root bit and updates the partial remainder.
module sqrt_step #(
   parameter int ROOT_W = 8
) (
   input  logic [ROOT_W:0]   rem_i,
   input  logic [ROOT_W-1:0] root_i,
   input  logic [1:0]        bits_i,
   output logic [ROOT_W:0]   rem_o,
   output logic [ROOT_W-1:0] root_o
);

   logic [ROOT_W+2:0] trial;
   logic [1:0]        unused_hi;

   // Trial subtract {rem, bits} - {root, 01}; keep it when non-negative, else restore.
   always_comb begin
      trial = {rem_i, bits_i} - {1'b0, root_i, 2'b01};
      unused_hi = '0;
      rem_o = '0;
      root_o = '0;
      if (!trial[ROOT_W+2]) begin
         {unused_hi, rem_o} = trial;
         root_o = {root_i[ROOT_W-2:0], 1'b1};
      end else begin
         // The restored value always fits ROOT_W+1 bits because rem <= 2*root.
         {unused_hi, rem_o} = {rem_i, bits_i};
         root_o = {root_i[ROOT_W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/sqrt_iter.sv
// Multi-cycle integer square root, STEPS root bits per clock, valid/ready on
// both sides. Returns floor(sqrt(x)) and the remainder x - root^2.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for an operand
//   BUSY  | applying STEPS iterations per clock, counter runs N-1 down to 0
//   DONE  | out_valid high, result held until out_ready
module sqrt_iter
   import sqrt_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int STEPS = 1,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_x,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH/2-1:0] out_root,
   output logic [WIDTH/2:0]   out_rem,
   output logic [TAG_W-1:0]   out_tag,
   output logic               busy
);

   localparam int ROOT_W = root_w(WIDTH);
   localparam int N      = ROOT_W / STEPS;
   localparam int CNT_W  = cnt_w(WIDTH, STEPS);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N - 1);

   if (!params_ok(WIDTH, STEPS)) begin : g_param_err
      $error("sqrt_iter: WIDTH must be even and >= 4, STEPS must divide WIDTH/2");
   end

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  op_q, op_d;
   logic [ROOT_W:0]   rem_q, rem_d;
   logic [ROOT_W-1:0] root_q, root_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d;

   logic [ROOT_W:0]   rem_c  [STEPS+1];
   logic [ROOT_W-1:0] root_c [STEPS+1];

   assign rem_c[0]  = rem_q;
   assign root_c[0] = root_q;

   // Chain of STEPS iterations, each eating the next-most-significant operand bit pair.
   for (genvar i = 0; i < STEPS; i++) begin : g_chain
      sqrt_step #(.ROOT_W(ROOT_W)) u_step (
         .rem_i  (rem_c[i]),
         .root_i (root_c[i]),
         .bits_i (op_q[WIDTH-1-2*i -: 2]),
         .rem_o  (rem_c[i+1]),
         .root_o (root_c[i+1])
      );
   end

   // Next-state and datapath updates; handshake outputs follow the next state.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      rem_d   = rem_q;
      root_d  = root_q;
      cnt_d   = cnt_q;
      tag_d   = tag_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_d    = in_x;
               tag_d   = in_tag;
               rem_d   = '0;
               root_d  = '0;
               cnt_d   = CNT_LOAD;
               state_d = BUSY;
            end
         end
         BUSY: begin
            rem_d  = rem_c[STEPS];
            root_d = root_c[STEPS];
            op_d   = op_q << (2 * STEPS);
            if (cnt_q == '0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   // State, datapath and registered handshake outputs; reset aborts any operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= '0;
         rem_q       <= '0;
         root_q      <= '0;
         cnt_q       <= '0;
         tag_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         rem_q       <= rem_d;
         root_q      <= root_d;
         cnt_q       <= cnt_d;
         tag_q       <= tag_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_root  = root_q;
   assign out_rem   = rem_q;
   assign out_tag   = tag_q;

endmodule

// File: tb/tb_sqrt_iter.sv
// Directed bench for sqrt_iter: three instances (16/1, 32/4, 16/4).
module tb_sqrt_iter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // instance A: WIDTH=16, STEPS=1
   logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_busy;
   logic [15:0] a_in_x = '0;
   logic [3:0]  a_in_tag = '0, a_tag;
   logic [7:0]  a_root;
   logic [8:0]  a_rem;

   // instance B: WIDTH=32, STEPS=4
   logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_busy;
   logic [31:0] b_in_x = '0;
   logic [3:0]  b_in_tag = '0, b_tag;
   logic [15:0] b_root;
   logic [16:0] b_rem;

   // instance C: WIDTH=16, STEPS=4
   logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b0, c_busy;
   logic [15:0] c_in_x = '0;
   logic [3:0]  c_in_tag = '0, c_tag;
   logic [7:0]  c_root;
   logic [8:0]  c_rem;

   sqrt_iter #(.WIDTH(16), .STEPS(1), .TAG_W(4)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_x(a_in_x), .in_tag(a_in_tag), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_root(a_root), .out_rem(a_rem), .out_tag(a_tag), .busy(a_busy));

   sqrt_iter #(.WIDTH(32), .STEPS(4), .TAG_W(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_x(b_in_x), .in_tag(b_in_tag), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_root(b_root), .out_rem(b_rem), .out_tag(b_tag), .busy(b_busy));

   sqrt_iter #(.WIDTH(16), .STEPS(4), .TAG_W(4)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .in_x(c_in_x), .in_tag(c_in_tag), .out_valid(c_out_valid), .out_ready(c_out_ready),
      .out_root(c_root), .out_rem(c_rem), .out_tag(c_tag), .busy(c_busy));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: integer square root by linear search.
   function automatic logic [31:0] ref_root(input logic [31:0] x);
      logic [31:0] r;
      r = 0;
      while ((64'(r) + 1) * (64'(r) + 1) <= 64'(x)) r++;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op_a(input logic [15:0] x, input logic [3:0] tag, input logic [7:0] er,
                       input logic [8:0] erem, input string nm);
      int t;
      t = 0;
      while (!a_in_ready && t < 50) begin tick(); t++; end
      chk({nm, "_inrdy"}, a_in_ready, 1);
      a_in_valid = 1'b1; a_in_x = x; a_in_tag = tag;
      tick();
      a_in_valid = 1'b0;
      t = 1;
      while (!a_out_valid && t < 60) begin tick(); t++; end
      chk({nm, "_lat"}, t, 9);
      chk({nm, "_root"}, a_root, er);
      chk({nm, "_rem"}, a_rem, erem);
      chk({nm, "_tag"}, a_tag, tag);
      a_out_ready = 1'b1;
      tick();
      a_out_ready = 1'b0;
      chk({nm, "_ready_after"}, a_in_ready, 1);
   endtask

   task automatic op_b(input logic [31:0] x, input logic [15:0] er, input logic [16:0] erem,
                       input string nm);
      int t;
      t = 0;
      while (!b_in_ready && t < 50) begin tick(); t++; end
      b_in_valid = 1'b1; b_in_x = x; b_in_tag = 4'd9;
      tick();
      b_in_valid = 1'b0;
      t = 1;
      while (!b_out_valid && t < 60) begin tick(); t++; end
      chk({nm, "_lat"}, t, 5);
      chk({nm, "_root"}, b_root, er);
      chk({nm, "_rem"}, b_rem, erem);
      chk({nm, "_tag"}, b_tag, 9);
      b_out_ready = 1'b1;
      tick();
      b_out_ready = 1'b0;
   endtask

   task automatic op_c(input logic [15:0] x, input logic [3:0] tag);
      int t;
      logic [31:0] r;
      r = ref_root({16'd0, x});
      t = 0;
      while (!c_in_ready && t < 50) begin tick(); t++; end
      c_in_valid = 1'b1; c_in_x = x; c_in_tag = tag;
      tick();
      c_in_valid = 1'b0;
      t = 1;
      while (!c_out_valid && t < 60) begin tick(); t++; end
      chk("c_lat", t, 3);
      chk("c_root", c_root, r);
      chk("c_rem", c_rem, x - r * r);
      chk("c_tag", c_tag, tag);
      c_out_ready = 1'b1;
      tick();
      c_out_ready = 1'b0;
   endtask

   initial begin
      int t;
      int seen;
      logic [15:0] x;
      logic [31:0] r;

      // reset values
      #12;
      chk("rst_in_ready", a_in_ready, 1);
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_root", a_root, 0);
      chk("rst_rem", a_rem, 0);
      chk("rst_tag", a_tag, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // directed vectors, WIDTH=16 STEPS=1
      op_a(16'd144,   4'd3,  8'd12,  9'd0,   "x144");
      op_a(16'd0,     4'd1,  8'd0,   9'd0,   "x0");
      op_a(16'd65535, 4'd15, 8'd255, 9'd510, "xmax");
      op_a(16'd2,     4'd2,  8'd1,   9'd1,   "x2");
      op_a(16'd255,   4'd4,  8'd15,  9'd30,  "x255");
      op_a(16'd256,   4'd5,  8'd16,  9'd0,   "x256");

      // back-pressure: result held, second operand refused
      a_in_valid = 1'b1; a_in_x = 16'd144; a_in_tag = 4'd3;
      tick();
      a_in_valid = 1'b0;
      t = 1;
      while (!a_out_valid && t < 60) begin tick(); t++; end
      chk("bp_lat", t, 9);
      a_in_valid = 1'b1; a_in_x = 16'd49; a_in_tag = 4'd5;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_valid", a_out_valid, 1);
         chk("bp_in_ready", a_in_ready, 0);
         chk("bp_root", a_root, 12);
         chk("bp_rem", a_rem, 0);
         chk("bp_tag", a_tag, 3);
      end
      a_out_ready = 1'b1;
      tick();
      a_out_ready = 1'b0;
      chk("bp_rel_ready", a_in_ready, 1);
      chk("bp_rel_valid", a_out_valid, 0);
      tick();
      a_in_valid = 1'b0;
      chk("bp_acc_busy", a_busy, 1);
      chk("bp_acc_ready", a_in_ready, 0);
      t = 1;
      while (!a_out_valid && t < 60) begin tick(); t++; end
      chk("bp2_lat", t, 9);
      chk("bp2_root", a_root, 7);
      chk("bp2_rem", a_rem, 0);
      chk("bp2_tag", a_tag, 5);
      a_out_ready = 1'b1;
      tick();
      a_out_ready = 1'b0;

      // reset asserted in BUSY cycle 4
      a_in_valid = 1'b1; a_in_x = 16'd144; a_in_tag = 4'd6;
      tick();
      a_in_valid = 1'b0;
      repeat (3) tick();
      chk("mid_busy_pre", a_busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_in_ready", a_in_ready, 1);
      chk("mid_out_valid", a_out_valid, 0);
      chk("mid_busy", a_busy, 0);
      chk("mid_root", a_root, 0);
      chk("mid_rem", a_rem, 0);
      chk("mid_tag", a_tag, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (a_out_valid) seen++;
      end
      chk("mid_no_valid", seen, 0);
      op_a(16'd2, 4'd7, 8'd1, 9'd1, "post_rst");

      // WIDTH=32, STEPS=4
      op_b(32'hFFFF_FFFF, 16'd65535, 17'd131070, "b_max");
      op_b(32'd1000000,   16'd1000,  17'd0,      "b_1e6");

      // sweep against reference model: STEPS=1 and STEPS=4
      for (int i = 0; i < 80; i++) begin
         x = (i < 16) ? 16'(i * i + (i & 1)) : 16'($urandom_range(0, 65535));
         r = ref_root({16'd0, x});
         op_a(x, 4'(i), 8'(r), 9'(x - r * r), "sweep_a");
      end
      for (int i = 0; i < 200; i++) begin
         x = (i < 20) ? 16'(65535 - i) : 16'($urandom_range(0, 65535));
         op_c(x, 4'(i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
